// File: rtl/mult_bist_pkg.sv
// mult_bist_pkg
//   Shared types and constants for the 8x8 multiplier BIST slice.
//   - state_t      : controller FSM states
//   - chk_entry_t  : one in-flight operand pair plus its exact product
//   - exact_prod() : reference 8x8 -> 16 product
package mult_bist_pkg;

  localparam int OP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int ERR_W   = 17;     // must hold 65536
  localparam int N_PAIRS = 65536;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] exact;
  } chk_entry_t;

  function automatic logic [PROD_W-1:0] exact_prod(input logic [OP_W-1:0] a,
                                                   input logic [OP_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

endpackage

// File: rtl/mult_bist_if.sv
// mult_bist_if
//   Bundle between the BIST controller and its environment (host control,
//   multiplier under test, result read-out).
//   master : the BIST controller (drives operands, status and results)
//   slave  : host + multiplier (drives start and dut_y)
//   SUM_W must match the SUM_W of the controller attached to it.
interface mult_bist_if #(parameter int SUM_W = 32);
  import mult_bist_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic               op_valid;
  logic [PROD_W-1:0]  dut_y;
  logic [ERR_W-1:0]   err_count;
  logic [SUM_W-1:0]   sum_ed;
  logic [PROD_W-1:0]  max_ed;
  logic [OP_W-1:0]    max_a;
  logic [OP_W-1:0]    max_b;

  modport master (
    input  start, dut_y,
    output busy, done, op_a, op_b, op_valid,
           err_count, sum_ed, max_ed, max_a, max_b
  );

  modport slave (
    output start, dut_y,
    input  busy, done, op_a, op_b, op_valid,
           err_count, sum_ed, max_ed, max_a, max_b
  );

endinterface

// File: rtl/mult_bist_chk.sv
// mult_bist_chk
//   Check pipe and error-distance accumulators.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : zero the accumulators (sweep start)
//     push        : entry describing the pair currently on op_a/op_b
//     dut_y       : multiplier result
//     err_count, sum_ed, max_ed, max_a, max_b : accumulated results
//   The pushed entry describes the operands visible in cycle t; after
//   LATENCY register stages it sits at the tail in cycle t+LATENCY, which is
//   exactly when the matching dut_y is presented.
module mult_bist_chk
  import mult_bist_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int SUM_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  chk_entry_t         push,
  input  logic [PROD_W-1:0]  dut_y,
  output logic [ERR_W-1:0]   err_count,
  output logic [SUM_W-1:0]   sum_ed,
  output logic [PROD_W-1:0]  max_ed,
  output logic [OP_W-1:0]    max_a,
  output logic [OP_W-1:0]    max_b
);

  genvar gi;

  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      chk_entry_t stage_reg;
      chk_entry_t stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = push;
      end else begin : g_link
        assign stage_in = g_stage[gi-1].stage_reg;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= '0;
        else        stage_reg <= stage_in;
      end
    end
  endgenerate

  chk_entry_t tail;
  assign tail = g_stage[LATENCY-1].stage_reg;

  // 17-bit signed difference; magnitude is at most 65535, so 16 bits hold it.
  logic signed [PROD_W:0] diff;
  logic [PROD_W-1:0]      ed;
  assign diff = $signed({1'b0, dut_y}) - $signed({1'b0, tail.exact});
  assign ed   = diff[PROD_W] ? PROD_W'(-diff) : PROD_W'(diff);

  logic [ERR_W-1:0]  err_count_reg;
  logic [SUM_W-1:0]  sum_ed_reg;
  logic [PROD_W-1:0] max_ed_reg;
  logic [OP_W-1:0]   max_a_reg;
  logic [OP_W-1:0]   max_b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
      sum_ed_reg    <= '0;
      max_ed_reg    <= '0;
      max_a_reg     <= '0;
      max_b_reg     <= '0;
    end else if (clear) begin
      err_count_reg <= '0;
      sum_ed_reg    <= '0;
      max_ed_reg    <= '0;
      max_a_reg     <= '0;
      max_b_reg     <= '0;
    end else if (tail.valid) begin
      if (ed != '0) begin
        err_count_reg <= err_count_reg + 1'b1;
        sum_ed_reg    <= sum_ed_reg + SUM_W'(ed);
      end
      // Strict compare: ties keep the earliest pair in sweep order.
      if (ed > max_ed_reg) begin
        max_ed_reg <= ed;
        max_a_reg  <= tail.a;
        max_b_reg  <= tail.b;
      end
    end
  end

  assign err_count = err_count_reg;
  assign sum_ed    = sum_ed_reg;
  assign max_ed    = max_ed_reg;
  assign max_a     = max_a_reg;
  assign max_b     = max_b_reg;

endmodule

// File: rtl/mult_bist_ctrl.sv
// mult_bist_ctrl
//   Exhaustive-sweep BIST for an 8x8 multiplier: issues every (a,b) pair,
//   a outer / b inner, one per cycle, and accumulates error statistics.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : mult_bist_if.master (start/busy/done, op_a/op_b/op_valid,
//              dut_y, err_count/sum_ed/max_ed/max_a/max_b)
//   LATENCY (1..8): cycles from op change to matching dut_y.
//   SUM_W: width of sum_ed, must match the attached interface.
module mult_bist_ctrl
  import mult_bist_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int SUM_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_bist_if.master bus
);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [3:0]  drain_reg, drain_next;
  logic        op_valid_reg, op_valid_next;
  logic        acc_clear;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    drain_next = drain_reg;
    acc_clear  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = SWEEP;
          cnt_next   = '0;
          drain_next = '0;
          acc_clear  = 1'b1;
        end
      end
      SWEEP: begin
        // cnt holds on the last pair so op_a/op_b stay at 255/255.
        if (cnt_reg == 16'(N_PAIRS - 1)) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_reg == 4'(LATENCY - 1)) state_next = DONE;
        else                              drain_next = drain_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
    op_valid_next = (state_next == SWEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      drain_reg    <= '0;
      op_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      drain_reg    <= drain_next;
      op_valid_reg <= op_valid_next;
    end
  end

  assign bus.op_a     = cnt_reg[15:8];
  assign bus.op_b     = cnt_reg[7:0];
  assign bus.op_valid = op_valid_reg;
  assign bus.busy     = (state_reg == SWEEP) || (state_reg == DRAIN);
  assign bus.done     = (state_reg == DONE);

  chk_entry_t push;
  assign push.valid = op_valid_reg;
  assign push.a     = cnt_reg[15:8];
  assign push.b     = cnt_reg[7:0];
  assign push.exact = exact_prod(cnt_reg[15:8], cnt_reg[7:0]);

  logic [ERR_W-1:0]  err_count_w;
  logic [SUM_W-1:0]  sum_ed_w;
  logic [PROD_W-1:0] max_ed_w;
  logic [OP_W-1:0]   max_a_w;
  logic [OP_W-1:0]   max_b_w;

  mult_bist_chk #(
    .LATENCY (LATENCY),
    .SUM_W   (SUM_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .push      (push),
    .dut_y     (bus.dut_y),
    .err_count (err_count_w),
    .sum_ed    (sum_ed_w),
    .max_ed    (max_ed_w),
    .max_a     (max_a_w),
    .max_b     (max_b_w)
  );

  assign bus.err_count = err_count_w;
  assign bus.sum_ed    = sum_ed_w;
  assign bus.max_ed    = max_ed_w;
  assign bus.max_a     = max_a_w;
  assign bus.max_b     = max_b_w;

endmodule
